// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers for the pipelined mux tree: how the binary select levels
// are split across register stages, plus parameter sanity checks.
package mux_tree_pipe_pkg;

  // Lower stages absorb the remainder, one extra level each.
  function automatic int levels_in_stage(input int k, input int sel_w, input int stages);
    return (sel_w / stages) + ((k < (sel_w % stages)) ? 1 : 0);
  endfunction

  function automatic int sel_lo(input int k, input int sel_w, input int stages);
    int lo;
    lo = 0;
    for (int i = 0; i < k; i++) lo += levels_in_stage(i, sel_w, stages);
    return lo;
  endfunction

  function automatic int group_size(input int levels);
    return 1 << levels;
  endfunction

  function automatic bit params_ok(input int n_in, input int stages, input int sel_w);
    return (n_in >= 2) && (stages >= 1) && (stages <= sel_w);
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One register stage of the mux tree: reduces groups of 2^LEVELS words and
// registers the result with the remaining select bits, error flag and valid.
module mux_tree_stage
  import mux_tree_pipe_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int IN_WORDS = 32,
  parameter int LEVELS   = 3,
  parameter int SEL_IN_W = 5
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic [IN_WORDS*WIDTH-1:0]                       in_data,
  input  logic [SEL_IN_W:0]                               in_tag,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  output logic [(IN_WORDS/group_size(LEVELS))*WIDTH-1:0]  out_data,
  output logic [SEL_IN_W-LEVELS:0]                        out_tag,
  output logic                                            out_valid,
  input  logic                                            out_ready
);

  localparam int GRP       = group_size(LEVELS);
  localparam int OUT_WORDS = IN_WORDS / GRP;
  localparam int TAG_OUT_W = SEL_IN_W - LEVELS + 1;

  // in_tag = {err, sel}; the low LEVELS bits pick within each group.
  logic [OUT_WORDS*WIDTH-1:0] red;
  logic                       advance;

  always_comb begin
    red = '0;
    for (int g = 0; g < OUT_WORDS; g++) begin
      red[g*WIDTH +: WIDTH] = in_data[(g*GRP + int'(in_tag[LEVELS-1:0]))*WIDTH +: WIDTH];
    end
  end

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= red;
        out_tag  <= TAG_OUT_W'(in_tag >> LEVELS);
      end
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 word multiplexer with valid/ready flow control. Out-of-range
// selects are carried as an error flag and produce a zero output word.
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int N_IN   = 32,
  parameter int STAGES = 2,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int PAD_WORDS = 1 << SEL_W;
  localparam logic [SEL_W:0] N_IN_L = (SEL_W+1)'(N_IN);

  if (!params_ok(N_IN, STAGES, SEL_W)) begin : g_bad_params
    $error("mux_tree_pipe: need N_IN >= 2 and 1 <= STAGES <= clog2(N_IN)");
  end

  logic [PAD_WORDS*WIDTH-1:0] padded;
  logic                       err;
  logic [STAGES:0]            vld;
  logic [STAGES:0]            rdy;

  assign padded   = (PAD_WORDS*WIDTH)'(in_data);
  assign err      = {1'b0, in_sel} >= N_IN_L;
  assign vld[0]   = in_valid;
  assign in_ready = rdy[0];
  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = sel_lo(k, SEL_W, STAGES);
    localparam int LV  = levels_in_stage(k, SEL_W, STAGES);
    localparam int SIW = SEL_W - LO;
    localparam int IW  = 1 << SIW;
    localparam int OW  = IW >> LV;

    logic [IW*WIDTH-1:0] d_in;
    logic [SIW:0]        t_in;
    logic [OW*WIDTH-1:0] d_out;
    logic [SIW-LV:0]     t_out;

    if (k == 0) begin : g_first
      assign d_in = padded;
      assign t_in = {err, in_sel};
    end else begin : g_next
      assign d_in = g_stg[k-1].d_out;
      assign t_in = g_stg[k-1].t_out;
    end

    mux_tree_stage #(
      .WIDTH    (WIDTH),
      .IN_WORDS (IW),
      .LEVELS   (LV),
      .SEL_IN_W (SIW)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (d_in),
      .in_tag    (t_in),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .out_data  (d_out),
      .out_tag   (t_out),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1])
    );
  end

  // After the last stage only the error bit remains in the tag.
  assign out_err   = g_stg[STAGES-1].t_out[0];
  assign out_data  = out_err ? '0 : g_stg[STAGES-1].d_out;
  assign out_valid = vld[STAGES];

endmodule
